countgen_multi: RTL and testbench

Multi-channel programmable pulse generator. It is the parametrised successor to the single-channel square-wave generator in the countgen library. It drives NCH independent outputs, each with a run-time period and high time (duty cycle) and a free-running or one-shot mode. Configuration is written through a valid/ready port and applied glitch-free at period boundaries. The block sits between a register/control front end and the pins or timers that consume the waveforms.

---
 rtl/countgen_pkg.sv | 19 +
 rtl/countgen_channel.sv | 98 +++++++++
 rtl/countgen_multi.sv | 58 +++++
 tb/tb_countgen_multi.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/countgen_pkg.sv
// Mode encodings and the configuration record shared by the countgen pulse generators.
package countgen_pkg;

  typedef logic mode_t;

  localparam mode_t MODE_FREE    = 1'b0;
  localparam mode_t MODE_ONESHOT = 1'b1;

  localparam int CFG_WIDTH = 32;

  typedef logic [CFG_WIDTH-1:0] cfg_val_t;

  typedef struct packed {
    cfg_val_t period;
    cfg_val_t high;
    mode_t    mode;
  } cfg_t;

endpackage

// File: rtl/countgen_channel.sv
// One pulse channel: counter, active/shadow config, pending flag; outputs registered one edge after en/start.
// A write is only offered while no shadow set is pending, so pending acts as the channel's backpressure.
module countgen_channel
  import countgen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_high,
  input  mode_t            i_mode,
  output logic             o_pend,
  output logic             o_out,
  output logic             o_wrap,
  output logic             o_busy
);

  typedef struct packed {
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high;
    mode_t            mode;
  } ch_cfg_t;

  ch_cfg_t          r_act;
  ch_cfg_t          r_shd;
  logic             r_pend;
  logic             r_run;
  logic             r_en_d;
  logic [WIDTH-1:0] r_cnt;
  logic             r_out;
  logic             r_wrap;

  ch_cfg_t          w_act_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_run_nxt;
  logic             w_rise;
  logic             w_wrap;
  logic             w_apply;

  assign w_rise    = i_en && !r_en_d;
  assign w_wrap    = r_run && (r_cnt == r_act.period - WIDTH'(1));
  assign w_apply   = r_pend && (w_wrap || i_start || w_rise || !r_run || !i_en);
  assign w_act_nxt = w_apply ? r_shd : r_act;

  // Restart uses the freshly applied set; a one-shot ends on the mode of the period that just finished.
  always_comb begin
    w_run_nxt = r_run;
    w_cnt_nxt = r_cnt;
    if (!i_en) begin
      w_run_nxt = 1'b0;
      w_cnt_nxt = '0;
    end else if (w_rise || i_start) begin
      w_run_nxt = (w_act_nxt.period != '0);
      w_cnt_nxt = '0;
    end else if (w_wrap) begin
      w_run_nxt = (r_act.mode == MODE_FREE) && (w_act_nxt.period != '0);
      w_cnt_nxt = '0;
    end else if (r_run) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act  <= '0;
      r_shd  <= '0;
      r_pend <= 1'b0;
      r_run  <= 1'b0;
      r_en_d <= 1'b0;
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_en_d <= i_en;
      r_act  <= w_act_nxt;
      if (i_wr) begin
        r_shd  <= '{period: i_period, high: i_high, mode: i_mode};
        r_pend <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
      r_run  <= w_run_nxt;
      r_cnt  <= w_cnt_nxt;
      r_out  <= w_run_nxt && (w_cnt_nxt < w_act_nxt.high);
      r_wrap <= w_run_nxt && (w_cnt_nxt == w_act_nxt.period - WIDTH'(1));
    end
  end

  assign o_pend = r_pend;
  assign o_out  = r_out;
  assign o_wrap = r_wrap;
  assign o_busy = r_run;

endmodule

// File: rtl/countgen_multi.sv
// NCH independent programmable pulse channels behind one config port; outputs registered, one edge latency.
// cfg_ready drops while the addressed channel holds a pending set; writes to absent channels are dropped.
module countgen_multi
  import countgen_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   wrap,
  output logic [NCH-1:0]   busy
);

  logic [NCH-1:0] w_pend;
  logic [NCH-1:0] w_wr;

  always_comb begin
    cfg_ready = 1'b1;
    w_wr      = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_ch == CH_W'(c)) begin
        cfg_ready = !w_pend[c];
        w_wr[c]   = cfg_valid && !w_pend[c];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    countgen_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_en     (en[g]),
      .i_start  (start[g]),
      .i_wr     (w_wr[g]),
      .i_period (cfg_period),
      .i_high   (cfg_high),
      .i_mode   (mode_t'(cfg_mode)),
      .o_pend   (w_pend[g]),
      .o_out    (out[g]),
      .o_wrap   (wrap[g]),
      .o_busy   (busy[g])
    );
  end

endmodule

// File: tb/tb_countgen_multi.sv
// Directed scenarios plus random traffic, checked every cycle against a behavioural channel model.
module tb_countgen_multi;
  import countgen_pkg::*;

  localparam int NCH   = 3;
  localparam int WIDTH = 8;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   en = '0;
  logic [NCH-1:0]   start = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [WIDTH-1:0] cfg_period = '0;
  logic [WIDTH-1:0] cfg_high = '0;
  logic             cfg_mode = 1'b0;
  logic [NCH-1:0]   out;
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   busy;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  countgen_multi #(.NCH(NCH), .WIDTH(WIDTH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_mode(cfg_mode),
    .out(out), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: per channel the active and shadow settings, position in period, running flag.
  int unsigned m_P[NCH], m_H[NCH], s_P[NCH], s_H[NCH], m_cnt[NCH];
  bit          m_mode[NCH], s_mode[NCH], m_pend[NCH], m_run[NCH], m_en_d[NCH];

  logic [31:0] c_out[NCH], c_wrap[NCH], c_busy[NCH], c_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_P[c] = 0; m_H[c] = 0; s_P[c] = 0; s_H[c] = 0; m_cnt[c] = 0;
      m_mode[c] = 0; s_mode[c] = 0; m_pend[c] = 0; m_run[c] = 0; m_en_d[c] = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      bit acc, rise, at_end, apply, old_mode;
      acc      = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
      rise     = en[c] && !m_en_d[c];
      at_end   = m_run[c] && (m_cnt[c] + 1 == m_P[c]);
      apply    = m_pend[c] && (at_end || start[c] || rise || !m_run[c] || !en[c]);
      old_mode = m_mode[c];
      if (apply) begin
        m_P[c] = s_P[c]; m_H[c] = s_H[c]; m_mode[c] = s_mode[c]; m_pend[c] = 0;
      end
      if (acc) begin
        s_P[c] = cfg_period; s_H[c] = cfg_high; s_mode[c] = cfg_mode; m_pend[c] = 1;
      end
      if (!en[c]) begin
        m_run[c] = 0; m_cnt[c] = 0;
      end else if (rise || start[c]) begin
        m_cnt[c] = 0; m_run[c] = (m_P[c] != 0);
      end else if (at_end) begin
        m_cnt[c] = 0;
        if (old_mode == MODE_ONESHOT || m_P[c] == 0) m_run[c] = 0;
      end else if (m_run[c]) begin
        m_cnt[c]++;
      end
      m_en_d[c] = en[c];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin : compare
    logic [NCH-1:0] eo, ew, eb;
    logic           er;
    if (chk_on) begin
      er = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        eo[c] = m_run[c] && (m_cnt[c] < m_H[c]);
        ew[c] = m_run[c] && (m_cnt[c] + 1 == m_P[c]);
        eb[c] = m_run[c];
        if (int'(cfg_ch) == c) er = !m_pend[c];
      end
      check("out", 32'(out), 32'(eo));
      check("wrap", 32'(wrap), 32'(ew));
      check("busy", 32'(busy), 32'(eb));
      check("cfg_ready", 32'(cfg_ready), 32'(er));
    end
  end

  task automatic capture(input int n);
    for (int c = 0; c < NCH; c++) begin
      c_out[c] = '0; c_wrap[c] = '0; c_busy[c] = '0;
    end
    c_rdy = '0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NCH; c++) begin
        c_out[c][i]  = out[c];
        c_wrap[c][i] = wrap[c];
        c_busy[c][i] = busy[c];
      end
      c_rdy[i] = cfg_ready;
      tick();
    end
  endtask

  task automatic cfg_write(input int ch, input int p, input int h, input bit mode);
    bit rdy;
    bit done = 1'b0;
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch);
    cfg_period = WIDTH'(p); cfg_high = WIDTH'(h); cfg_mode = mode;
    for (int i = 0; i < 64; i++) begin
      rdy = 1'b1;
      for (int c = 0; c < NCH; c++) if (c == ch) rdy = !m_pend[c];
      tick();
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    cfg_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL cfg_write_timeout: got no accept expected accept within 64 cycles on ch %0d", ch);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    chk_on = 1'b1;
    check("rst_out", 32'(out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rdy", 32'(cfg_ready), 1);
    rst = 1'b0;

    // Two free-running channels started together.
    cfg_write(0, 10, 3, MODE_FREE);
    cfg_write(1, 4, 2, MODE_FREE);
    en = 3'b011;
    tick();
    capture(20);
    check("p10_out", c_out[0], 32'h000701C0 >> 6);
    check("p10_wrap", c_wrap[0], 32'h00080200);
    check("p10_busy", c_busy[0], 32'h000FFFFF);
    check("p4_out", c_out[1], 32'h00033333);
    check("p4_wrap", c_wrap[1], 32'h00088888);

    // Mid-period rewrite: the running period finishes first.
    repeat (3) tick();
    cfg_write(0, 6, 6, MODE_FREE);
    #1 check("rewrite_rdy_low", 32'(cfg_ready), 0);
    capture(16);
    check("rewrite_out", c_out[0], 32'h0000FFC0);
    check("rewrite_wrap", c_wrap[0], 32'h00000820);
    check("rewrite_rdy", c_rdy, 32'h0000FFC0);

    // One-shot pulse, then re-armed by start.
    cfg_write(2, 5, 2, MODE_ONESHOT);
    en = 3'b111;
    tick();
    capture(8);
    check("os_out", c_out[2], 32'h03);
    check("os_wrap", c_wrap[2], 32'h10);
    check("os_busy", c_busy[2], 32'h1F);
    start = 3'b100;
    tick();
    start = 3'b000;
    capture(8);
    check("os2_out", c_out[2], 32'h03);
    check("os2_wrap", c_wrap[2], 32'h10);
    check("os2_busy", c_busy[2], 32'h1F);

    // Degenerate settings on channel 1.
    en = 3'b101; tick();
    cfg_write(1, 0, 3, MODE_FREE);
    en = 3'b111; tick();
    capture(5);
    check("p0_busy", c_busy[1], 32'h0);
    en = 3'b101; tick();
    cfg_write(1, 1, 1, MODE_FREE);
    en = 3'b111; tick();
    capture(6);
    check("p1_out", c_out[1], 32'h3F);
    check("p1_wrap", c_wrap[1], 32'h3F);
    en = 3'b101; tick();
    cfg_write(1, 5, 0, MODE_FREE);
    en = 3'b111; tick();
    capture(10);
    check("h0_out", c_out[1], 32'h0);
    check("h0_busy", c_busy[1], 32'h3FF);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd9;
    #1 check("drop_rdy", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;

    // Same-cycle start on channels 0 and 2 aligns their phase.
    cfg_write(0, 10, 3, MODE_FREE);
    cfg_write(2, 10, 3, MODE_FREE);
    repeat (4) tick();
    start = 3'b101;
    tick();
    start = 3'b000;
    capture(12);
    check("align_out0", c_out[0], 32'hC07);
    check("align_out2", c_out[2], 32'hC07);
    check("align_wrap0", c_wrap[0], 32'h200);
    check("align_wrap2", c_wrap[2], 32'h200);

    // Reset mid-period with a pending write.
    cfg_write(0, 7, 2, MODE_FREE);
    cfg_ch = 2'd0;
    #1 check("pend_rdy_low", 32'(cfg_ready), 0);
    rst = 1'b1;
    tick();
    check("mid_rst_out", 32'(out), 0);
    check("mid_rst_wrap", 32'(wrap), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rdy", 32'(cfg_ready), 1);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) en[$urandom_range(NCH-1)] ^= 1'b1;
      for (int c = 0; c < NCH; c++) start[c] = ($urandom_range(15) == 0);
      cfg_valid  = ($urandom_range(3) == 0);
      cfg_ch     = CH_W'($urandom_range(3));
      cfg_period = WIDTH'($urandom_range(12));
      cfg_high   = WIDTH'($urandom_range(14));
      cfg_mode   = 1'($urandom_range(1));
      rst        = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0; cfg_valid = 1'b0; start = '0;
    tick();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
